sid_phase_sched: RTL
====================

SID_PHASE_SCHED -- requirements
Module: sid_phase_sched

Interface
REQ-001 Parameter CYCLE_LEN, default 32, system clocks per SID cycle; the block SHALL support any even value from 8 to 256.
REQ-002 Parameter MS_CYCLES, default 1000, SID cycles per tick_ms; the block SHALL support any value from 2 to 65535.
REQ-003 clk  in  1  system clock; all state SHALL be clocked on posedge clk.
REQ-004 res_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 run  in  1  enable SID cycle sequencing.
REQ-006 wr_req  in  1  register-write request from the bus interface; held high until granted.
REQ-007 wr_ack  out  1  one-clock grant pulse for wr_req.
REQ-008 phase  out  3  one-hot strobes: [0] PHI1, [1] PHI2, [2] PHI2_PHI1.
REQ-009 voice_stb  out  1  shared waveform datapath evaluation slot.
REQ-010 voice_idx  out  2  voice served in the current slot, 0..2.
REQ-011 tick_ms  out  1  one-clock millisecond tick, coincident with a PHI2_PHI1 strobe.
REQ-012 busy  out  1  high while state is RUN or STOP.

Function
REQ-013 State machine SHALL have states IDLE, RUN, STOP; the cycle counter cnt SHALL count 0..CYCLE_LEN-1 in RUN and STOP, and wrap to 0.
REQ-014 IDLE: cnt held at 0; phase, voice_stb, tick_ms SHALL be 0; IDLE->RUN when run=1, with cnt=0 on the first RUN clock.
REQ-015 RUN->STOP when run=0 is sampled at any cnt; STOP SHALL finish the current SID cycle, then STOP->IDLE on the clock after cnt=CYCLE_LEN-1.
REQ-016 run=1 sampled in STOP SHALL NOT return to RUN; the block SHALL return to RUN only via IDLE, with at least one clock in IDLE.
REQ-017 In RUN/STOP, phase[0] SHALL be 1 exactly when cnt=0, phase[1] exactly when cnt=CYCLE_LEN/2, and phase[2] exactly when cnt=CYCLE_LEN-1.
REQ-018 voice_stb SHALL be 1 exactly when cnt is 1, 2 or 3, with voice_idx 0, 1, 2 respectively.
REQ-019 voice_idx SHALL be 0 whenever voice_stb=0.
REQ-020 Outputs phase, voice_stb, voice_idx, tick_ms, wr_ack SHALL be registered, taking effect in the same clock as the cnt value that defines them (decode from next-state).
REQ-021 Voice order SHALL be fixed 0,1,2 every SID cycle, so sync source n-1 is evaluated before destination n.
REQ-022 ms counter SHALL increment at each PHI2_PHI1 strobe; at MS_CYCLES-1 it SHALL wrap to 0 and assert tick_ms in that strobe clock.
REQ-023 The ms counter SHALL hold its value in IDLE.
REQ-024 Blocked slots are cnt in {1,2,3,CYCLE_LEN-1} in RUN/STOP; in IDLE no slot is blocked.
REQ-025 wr_ack SHALL pulse for one clock in the first non-blocked clock with wr_req=1.
REQ-026 After a wr_ack pulse, wr_ack SHALL be 0 in the following clock, even if wr_req remains 1 (minimum 2-clock grant spacing).
REQ-027 wr_req deasserted before a grant SHALL be dropped without wr_ack.

Reset
REQ-028 res_n=0 SHALL immediately force state IDLE, cnt=0, ms counter=0, and all outputs 0, regardless of clk.
REQ-029 Reset deasserted mid-cycle SHALL restart sequencing from IDLE; no partial SID cycle or stale strobe SHALL be emitted.

Verification
REQ-030 CYCLE_LEN=32, run=1 held from reset release: phase=001 at cnt 0, 010 at 16, 100 at 31; voice_stb at cnt 1,2,3 with idx 0,1,2; pattern repeats every 32 clocks.
REQ-031 MS_CYCLES=4, run held: tick_ms pulses on the PHI2_PHI1 strobe of every 4th SID cycle (cycles 4, 8, ...), and never elsewhere.
REQ-032 wr_req=1 asserted when cnt=1 and held until granted: wr_ack occurs at cnt=4; wr_req held 3 more clocks: next wr_ack at cnt=6.
REQ-033 run dropped at cnt=10: strobes continue through cnt=31, busy falls one clock later, and run re-raised at cnt=20 is ignored until IDLE.
REQ-034 res_n pulsed low asynchronously at cnt=2 with voice_stb=1: all outputs 0 at once; after release with run=1, first PHI1 after one IDLE clock.
REQ-035 In IDLE, wr_req=1 for 5 clocks: wr_ack pattern 1,0,1,0,1.

Source files
------------

// File: rtl/sid_phase_sched.sv
// sid_phase_sched: SID cycle phase/voice-slot sequencer with millisecond tick
// and bus write-slot arbitration around the shared waveform datapath.
module sid_phase_sched #(
    parameter int CYCLE_LEN = 32,
    parameter int MS_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       run,
    input  logic       wr_req,
    output logic       wr_ack,
    output logic [2:0] phase,
    output logic       voice_stb,
    output logic [1:0] voice_idx,
    output logic       tick_ms,
    output logic       busy
);
    localparam int CW = $clog2(CYCLE_LEN);
    localparam int MW = $clog2(MS_CYCLES);
    localparam logic [CW-1:0] C_LAST = CW'(CYCLE_LEN - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CYCLE_LEN / 2);
    localparam logic [MW-1:0] M_LAST = MW'(MS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [MW-1:0] ms_q, ms_d;
    logic [2:0]    phase_q, phase_d;
    logic [1:0]    voice_idx_q, voice_idx_d;
    logic          voice_stb_q, voice_stb_d;
    logic          tick_ms_q, tick_ms_d;
    logic          wr_ack_q, wr_ack_d;
    logic          active, blocked;

    always_comb begin
        cnt_inc = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        state_d = state_q;
        cnt_d   = cnt_inc;
        case (state_q)
            IDLE: begin
                state_d = run ? RUN : IDLE;
                cnt_d   = '0;
            end
            RUN:  if (!run) state_d = (cnt_q == C_LAST) ? IDLE : STOP;
            STOP: if (cnt_q == C_LAST) state_d = IDLE;
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Outputs decode the upcoming state so they line up with the cnt they describe
        active      = state_d != IDLE;
        phase_d     = active ? {cnt_d == C_LAST, cnt_d == C_HALF, cnt_d == '0} : 3'b000;
        voice_stb_d = active && cnt_d >= CW'(1) && cnt_d <= CW'(3);
        voice_idx_d = voice_stb_d ? 2'(cnt_d - CW'(1)) : 2'd0;
        blocked     = active && (voice_stb_d || cnt_d == C_LAST);
        wr_ack_d    = wr_req && !blocked && !wr_ack_q;
        ms_d        = phase_d[2] ? ((ms_q == M_LAST) ? '0 : ms_q + MW'(1)) : ms_q;
        tick_ms_d   = phase_d[2] && ms_q == M_LAST;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ms_q        <= '0;
            phase_q     <= '0;
            voice_stb_q <= 1'b0;
            voice_idx_q <= '0;
            tick_ms_q   <= 1'b0;
            wr_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ms_q        <= ms_d;
            phase_q     <= phase_d;
            voice_stb_q <= voice_stb_d;
            voice_idx_q <= voice_idx_d;
            tick_ms_q   <= tick_ms_d;
            wr_ack_q    <= wr_ack_d;
        end
    end

    assign phase     = phase_q;
    assign voice_stb = voice_stb_q;
    assign voice_idx = voice_idx_q;
    assign tick_ms   = tick_ms_q;
    assign wr_ack    = wr_ack_q;
    assign busy      = state_q != IDLE;
endmodule
